// File: rtl/writeback_stage.sv
// MEM/WB pipeline register and writeback stage.
// Captures one memory-stage result per memory_done assertion. It then aligns and extends
// the load data and selects the writeback source. It issues one register-file write per
// instruction and drives a forwarding copy of the value while the instruction is in flight.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   memory_done                level from memory stage, result ready
//   loaded_data, alu_data, pc  raw cache doubleword, ALU result/address, instruction PC
//   rd_addr, reg_write         destination register and write intent
//   mem_to_reg, link           writeback source select (link has priority)
//   data_size, load_unsigned   load width (log2 bytes) and zero-extend select
//   mem_wb_pipeline_valid      one-cycle pulse when a new instruction is captured
//   rf_write_*                 register-file write port
//   fwd_*                      forwarding entry (valid only for rd != 0 with reg_write)
//   wb_done                    one-cycle retire pulse
module writeback_stage #(
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      memory_done,
    input  logic [DATA_WIDTH-1:0]     loaded_data,
    input  logic [DATA_WIDTH-1:0]     alu_data,
    input  logic [DATA_WIDTH-1:0]     pc,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr,
    input  logic                      reg_write,
    input  logic                      mem_to_reg,
    input  logic                      link,
    input  logic [1:0]                data_size,
    input  logic                      load_unsigned,
    output logic                      mem_wb_pipeline_valid,
    output logic                      rf_write_enable,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_addr,
    output logic [DATA_WIDTH-1:0]     rf_write_data,
    output logic                      fwd_valid,
    output logic [REG_ADDR_WIDTH-1:0] fwd_rd,
    output logic [DATA_WIDTH-1:0]     fwd_data,
    output logic                      wb_done
);

    typedef enum logic [1:0] {StIdle, StCapture, StCommit} state_e;

    state_e                    state;
    logic                      armed;

    // MEM/WB register
    logic [DATA_WIDTH-1:0]     lat_loaded;
    logic [DATA_WIDTH-1:0]     lat_alu;
    logic [DATA_WIDTH-1:0]     lat_pc;
    logic [REG_ADDR_WIDTH-1:0] lat_rd;
    logic                      lat_reg_write;
    logic                      lat_mem_to_reg;
    logic                      lat_link;
    logic [1:0]                lat_size;
    logic                      lat_unsigned;

    logic [DATA_WIDTH-1:0]     shifted;
    logic [DATA_WIDTH-1:0]     load_value;
    logic [DATA_WIDTH-1:0]     wb_value;
    logic                      in_flight;

    // Byte lane select; bytes shifted in from beyond the doubleword read as zero.
    always_comb begin
        shifted    = lat_loaded >> {lat_alu[2:0], 3'b000};
        load_value = shifted;
        unique case (lat_size)
            2'd0: load_value = lat_unsigned ? {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]}
                                            : {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            2'd1: load_value = lat_unsigned ? {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]}
                                            : {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            2'd2: load_value = lat_unsigned ? {{(DATA_WIDTH-32){1'b0}}, shifted[31:0]}
                                            : {{(DATA_WIDTH-32){shifted[31]}}, shifted[31:0]};
            default: load_value = shifted;
        endcase
    end

    always_comb begin
        if (lat_link) begin
            wb_value = lat_pc + DATA_WIDTH'(4);
        end else if (lat_mem_to_reg) begin
            wb_value = load_value;
        end else begin
            wb_value = lat_alu;
        end
    end

    // Forwarding mirrors the MEM/WB register while an instruction is in flight.
    always_comb begin
        in_flight = (state == StCapture) || (state == StCommit);
        fwd_valid = in_flight && lat_reg_write && (lat_rd != '0);
        fwd_rd    = in_flight ? lat_rd : '0;
        fwd_data  = in_flight ? wb_value : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                 <= StIdle;
            armed                 <= 1'b1;
            mem_wb_pipeline_valid <= 1'b0;
            rf_write_enable       <= 1'b0;
            rf_write_addr         <= '0;
            rf_write_data         <= '0;
            wb_done               <= 1'b0;
            lat_loaded            <= '0;
            lat_alu               <= '0;
            lat_pc                <= '0;
            lat_rd                <= '0;
            lat_reg_write         <= 1'b0;
            lat_mem_to_reg        <= 1'b0;
            lat_link              <= 1'b0;
            lat_size              <= 2'd0;
            lat_unsigned          <= 1'b0;
        end else begin
            mem_wb_pipeline_valid <= 1'b0;
            rf_write_enable       <= 1'b0;
            rf_write_addr         <= '0;
            rf_write_data         <= '0;
            wb_done               <= 1'b0;
            // A low sample re-arms; a held-high memory_done cannot capture twice.
            if (!memory_done) begin
                armed <= 1'b1;
            end
            unique case (state)
                StIdle: begin
                    if (memory_done && armed) begin
                        lat_loaded            <= loaded_data;
                        lat_alu               <= alu_data;
                        lat_pc                <= pc;
                        lat_rd                <= rd_addr;
                        lat_reg_write         <= reg_write;
                        lat_mem_to_reg        <= mem_to_reg;
                        lat_link              <= link;
                        lat_size              <= data_size;
                        lat_unsigned          <= load_unsigned;
                        armed                 <= 1'b0;
                        mem_wb_pipeline_valid <= 1'b1;
                        state                 <= StCapture;
                    end
                end
                StCapture: begin
                    rf_write_enable <= lat_reg_write && (lat_rd != '0);
                    rf_write_addr   <= lat_rd;
                    rf_write_data   <= wb_value;
                    wb_done         <= 1'b1;
                    state           <= StCommit;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_stage.sv
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        memory_done;
    logic [63:0] loaded_data, alu_data, pc;
    logic [4:0]  rd_addr;
    logic        reg_write, mem_to_reg, link, load_unsigned;
    logic [1:0]  data_size;
    logic        mem_wb_pipeline_valid, rf_write_enable, fwd_valid, wb_done;
    logic [4:0]  rf_write_addr, fwd_rd;
    logic [63:0] rf_write_data, fwd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    writeback_stage dut (
        .clk                   (clk),
        .reset                 (reset),
        .memory_done           (memory_done),
        .loaded_data           (loaded_data),
        .alu_data              (alu_data),
        .pc                    (pc),
        .rd_addr               (rd_addr),
        .reg_write             (reg_write),
        .mem_to_reg            (mem_to_reg),
        .link                  (link),
        .data_size             (data_size),
        .load_unsigned         (load_unsigned),
        .mem_wb_pipeline_valid (mem_wb_pipeline_valid),
        .rf_write_enable       (rf_write_enable),
        .rf_write_addr         (rf_write_addr),
        .rf_write_data         (rf_write_data),
        .fwd_valid             (fwd_valid),
        .fwd_rd                (fwd_rd),
        .fwd_data              (fwd_data),
        .wb_done               (wb_done)
    );

    typedef struct {
        string       name;
        logic [63:0] loaded;
        logic [63:0] alu;
        logic [63:0] pcv;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic        lnk;
        logic [1:0]  size;
        logic        uns;
        logic [63:0] exp_data;
        logic        exp_we;
        logic        exp_fv;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, actual, expected);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, ".valid"}, 64'(mem_wb_pipeline_valid), 64'd0);
        chk({tag, ".we"}, 64'(rf_write_enable), 64'd0);
        chk({tag, ".waddr"}, 64'(rf_write_addr), 64'd0);
        chk({tag, ".wdata"}, rf_write_data, 64'd0);
        chk({tag, ".fwd_valid"}, 64'(fwd_valid), 64'd0);
        chk({tag, ".wb_done"}, 64'(wb_done), 64'd0);
    endtask

    task automatic drive(input vec_t v);
        loaded_data   = v.loaded;
        alu_data      = v.alu;
        pc            = v.pcv;
        rd_addr       = v.rd;
        reg_write     = v.rw;
        mem_to_reg    = v.m2r;
        link          = v.lnk;
        data_size     = v.size;
        load_unsigned = v.uns;
    endtask

    // Called at a negedge with the DUT idle and armed.
    task automatic run_vec(input vec_t v);
        drive(v);
        memory_done = 1'b1;
        @(negedge clk);
        chk({v.name, ".capture_valid"}, 64'(mem_wb_pipeline_valid), 64'd1);
        chk({v.name, ".capture_we"}, 64'(rf_write_enable), 64'd0);
        chk({v.name, ".capture_fwd_valid"}, 64'(fwd_valid), 64'(v.exp_fv));
        if (v.exp_fv) chk({v.name, ".capture_fwd_data"}, fwd_data, v.exp_data);
        memory_done = 1'b0;
        drive('{"x", '0, '0, '0, '0, 0, 0, 0, 0, 0, '0, 0, 0});
        @(negedge clk);
        chk({v.name, ".commit_valid"}, 64'(mem_wb_pipeline_valid), 64'd0);
        chk({v.name, ".commit_we"}, 64'(rf_write_enable), 64'(v.exp_we));
        if (v.exp_we) begin
            chk({v.name, ".commit_addr"}, 64'(rf_write_addr), 64'(v.rd));
            chk({v.name, ".commit_data"}, rf_write_data, v.exp_data);
        end
        chk({v.name, ".commit_wb_done"}, 64'(wb_done), 64'd1);
        chk({v.name, ".commit_fwd_valid"}, 64'(fwd_valid), 64'(v.exp_fv));
        if (v.exp_fv) begin
            chk({v.name, ".commit_fwd_rd"}, 64'(fwd_rd), 64'(v.rd));
            chk({v.name, ".commit_fwd_data"}, fwd_data, v.exp_data);
        end
        @(negedge clk);
        check_idle_outputs({v.name, ".after"});
    endtask

    int pv_cnt, we_cnt;

    initial begin
        // name, loaded, alu, pc, rd, rw, m2r, link, size, uns, exp_data, exp_we, exp_fv
        vecs[0]  = '{"alu", 64'h0, 64'h1000, 64'h0, 5'd5, 1, 0, 0, 2'd0, 0,
                     64'h1000, 1, 1};
        vecs[1]  = '{"lb", 64'h0000_0000_0080_0000, 64'h2002, 64'h0, 5'd6, 1, 1, 0, 2'd0, 0,
                     64'hFFFF_FFFF_FFFF_FF80, 1, 1};
        vecs[2]  = '{"lbu", 64'h0000_0000_0080_0000, 64'h2002, 64'h0, 5'd6, 1, 1, 0, 2'd0, 1,
                     64'h80, 1, 1};
        vecs[3]  = '{"link_wrap", 64'h0, 64'h55, 64'hFFFF_FFFF_FFFF_FFFC, 5'd1, 1, 0, 1, 2'd0, 0,
                     64'h0, 1, 1};
        vecs[4]  = '{"link_prio", 64'h1111, 64'h8, 64'h2000, 5'd2, 1, 1, 1, 2'd3, 0,
                     64'h2004, 1, 1};
        vecs[5]  = '{"rd0", 64'h0, 64'h1234, 64'h0, 5'd0, 1, 0, 0, 2'd0, 0,
                     64'h1234, 0, 0};
        vecs[6]  = '{"lh", 64'h1234_8000_0000_0000, 64'h4, 64'h0, 5'd7, 1, 1, 0, 2'd1, 0,
                     64'hFFFF_FFFF_FFFF_8000, 1, 1};
        vecs[7]  = '{"lwu", 64'hDEAD_BEEF_0000_0000, 64'h4, 64'h0, 5'd8, 1, 1, 0, 2'd2, 1,
                     64'h0000_0000_DEAD_BEEF, 1, 1};
        vecs[8]  = '{"lw", 64'hDEAD_BEEF_0000_0000, 64'h4, 64'h0, 5'd9, 1, 1, 0, 2'd2, 0,
                     64'hFFFF_FFFF_DEAD_BEEF, 1, 1};
        vecs[9]  = '{"ld_uns", 64'h8000_0000_0000_0001, 64'h10, 64'h0, 5'd31, 1, 1, 0, 2'd3, 1,
                     64'h8000_0000_0000_0001, 1, 1};
        vecs[10] = '{"lh_cross", 64'hAB00_0000_0000_0000, 64'h7, 64'h0, 5'd3, 1, 1, 0, 2'd1, 0,
                     64'hAB, 1, 1};

        reset       = 1'b1;
        memory_done = 1'b0;
        drive('{"x", '0, '0, '0, '0, 0, 0, 0, 0, 0, '0, 0, 0});
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            run_vec(vecs[i]);
        end

        // memory_done held high for 6 cycles: one capture only.
        pv_cnt = 0;
        we_cnt = 0;
        drive(vecs[0]);
        memory_done = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            pv_cnt += int'(mem_wb_pipeline_valid);
            we_cnt += int'(rf_write_enable);
        end
        chk("held.valid_pulses", 64'(pv_cnt), 64'd1);
        chk("held.writes", 64'(we_cnt), 64'd1);
        // One low cycle re-arms; the next high is captured.
        memory_done = 1'b0;
        @(negedge clk);
        memory_done = 1'b1;
        pv_cnt = 0;
        we_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            pv_cnt += int'(mem_wb_pipeline_valid);
            we_cnt += int'(rf_write_enable);
        end
        chk("rearm.valid_pulses", 64'(pv_cnt), 64'd1);
        chk("rearm.writes", 64'(we_cnt), 64'd1);
        memory_done = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("rearm.after");

        // Reset while in CAPTURE drops the instruction.
        drive(vecs[0]);
        memory_done = 1'b1;
        @(negedge clk);
        chk("rst_mid.capture_valid", 64'(mem_wb_pipeline_valid), 64'd1);
        reset       = 1'b1;
        memory_done = 1'b0;
        @(negedge clk);
        check_idle_outputs("rst_mid.next");
        reset = 1'b0;
        we_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            we_cnt += int'(rf_write_enable);
        end
        chk("rst_mid.no_write", 64'(we_cnt), 64'd0);
        run_vec(vecs[7]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
